raster_addr_gen: RTL and testbench

- Two-level (row/column) address sequencer that generates pixel/weight read addresses for a rectangular window of a row-major buffer.
- Sits directly upstream of the layer counters and memories. It supplies the address stream and the row/column indices, and indicates completion when the window is exhausted.
- Handles windows such as a 28x28 MNIST image or sub-tiles of a feature map, one address per cycle under valid/ready back-pressure.

---
 rtl/raster_addr_gen.sv | 143 ++++++++++++++
 tb/tb_raster_addr_gen.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/raster_addr_gen.sv
// rtl/raster_addr_gen.sv - row/column address sequencer for a rectangular window of a row-major buffer
module raster_addr_gen #(
    parameter int AddrBits = 16,
    parameter int DimBits  = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [AddrBits-1:0] base_addr_i,
    input  logic [DimBits-1:0]  cols_i,
    input  logic [DimBits-1:0]  rows_i,
    input  logic [AddrBits-1:0] row_stride_i,
    input  logic                ready_i,
    output logic [AddrBits-1:0] addr_o,
    output logic [DimBits-1:0]  col_o,
    output logic [DimBits-1:0]  row_o,
    output logic                valid_o,
    output logic                last_o,
    output logic                busy_o,
    output logic                done_o
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t              r_state;
    logic [AddrBits-1:0] r_addr;
    logic [AddrBits-1:0] r_row_base;
    logic [AddrBits-1:0] r_stride;
    logic [DimBits-1:0]  r_cols;
    logic [DimBits-1:0]  r_rows;
    logic [DimBits-1:0]  r_col;
    logic [DimBits-1:0]  r_row;
    logic                r_valid;
    logic                r_last;
    logic                r_busy;
    logic                r_done;

    logic                w_xfer;
    logic                w_end_col;
    logic                w_end_row;
    logic [DimBits-1:0]  w_next_col;
    logic [DimBits-1:0]  w_next_row;
    logic [AddrBits-1:0] w_next_row_base;
    logic [AddrBits-1:0] w_next_addr;
    logic                w_next_last;
    logic                w_start_empty;

    assign w_xfer          = (r_state == S_RUN) && ready_i;
    assign w_end_col       = (r_col == r_cols - DimBits'(1));
    assign w_end_row       = (r_row == r_rows - DimBits'(1));
    assign w_next_col      = w_end_col ? '0 : r_col + DimBits'(1);
    assign w_next_row      = w_end_col ? r_row + DimBits'(1) : r_row;
    assign w_next_row_base = r_row_base + r_stride;
    assign w_next_addr     = w_end_col ? w_next_row_base : r_addr + AddrBits'(1);
    // last is registered, so it is computed for the beat we are about to present
    assign w_next_last     = (w_next_col == r_cols - DimBits'(1)) &&
                             (w_next_row == r_rows - DimBits'(1));
    assign w_start_empty   = (cols_i == '0) || (rows_i == '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_row_base <= '0;
            r_stride   <= '0;
            r_cols     <= '0;
            r_rows     <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start_i) begin
                        r_cols   <= cols_i;
                        r_rows   <= rows_i;
                        r_stride <= row_stride_i;
                        r_busy   <= 1'b1;
                        if (w_start_empty) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= S_RUN;
                            r_addr     <= base_addr_i;
                            r_row_base <= base_addr_i;
                            r_col      <= '0;
                            r_row      <= '0;
                            r_valid    <= 1'b1;
                            r_last     <= (cols_i == DimBits'(1)) && (rows_i == DimBits'(1));
                        end
                    end
                end
                S_RUN: begin
                    if (w_xfer) begin
                        if (w_end_col && w_end_row) begin
                            r_state <= S_DONE;
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_addr <= w_next_addr;
                            r_col  <= w_next_col;
                            r_row  <= w_next_row;
                            r_last <= w_next_last;
                            if (w_end_col) begin
                                r_row_base <= w_next_row_base;
                            end
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        assert (!(r_valid && !r_busy));
    end

    assign addr_o  = r_addr;
    assign col_o   = r_col;
    assign row_o   = r_row;
    assign valid_o = r_valid;
    assign last_o  = r_last;
    assign busy_o  = r_busy;
    assign done_o  = r_done;

endmodule

// File: tb/tb_raster_addr_gen.sv
// tb/tb_raster_addr_gen.sv - directed self-checking bench for raster_addr_gen
module tb_raster_addr_gen;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [15:0] base_addr_i;
    logic [7:0]  cols_i;
    logic [7:0]  rows_i;
    logic [15:0] row_stride_i;
    logic        ready_i;
    logic [15:0] addr_o;
    logic [7:0]  col_o;
    logic [7:0]  row_o;
    logic        valid_o;
    logic        last_o;
    logic        busy_o;
    logic        done_o;

    int n_pass  = 0;
    int n_total = 0;

    raster_addr_gen #(.AddrBits(16), .DimBits(8)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .base_addr_i  (base_addr_i),
        .cols_i       (cols_i),
        .rows_i       (rows_i),
        .row_stride_i (row_stride_i),
        .ready_i      (ready_i),
        .addr_o       (addr_o),
        .col_o        (col_o),
        .row_o        (row_o),
        .valid_o      (valid_o),
        .last_o       (last_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_beat(input string tag, input logic [15:0] a, input logic [7:0] r,
                            input logic [7:0] c, input logic l);
        chk({tag, ".valid"}, {31'd0, valid_o}, 32'd1);
        chk({tag, ".addr"},  {16'd0, addr_o},  {16'd0, a});
        chk({tag, ".row"},   {24'd0, row_o},   {24'd0, r});
        chk({tag, ".col"},   {24'd0, col_o},   {24'd0, c});
        chk({tag, ".last"},  {31'd0, last_o},  {31'd0, l});
    endtask

    task automatic start_win(input logic [15:0] b, input logic [7:0] c, input logic [7:0] r,
                             input logic [15:0] s);
        base_addr_i  = b;
        cols_i       = c;
        rows_i       = r;
        row_stride_i = s;
        start_i      = 1'b1;
        tick();
        start_i      = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1);
    end

    initial begin
        logic [15:0] exp_a [0:5];
        logic [15:0] bp_a  [0:3];
        logic [15:0] wr_a  [0:3];
        logic        rdy_seq [0:6];
        int          k;

        rst_i = 1'b1; start_i = 1'b0; ready_i = 1'b0;
        base_addr_i = '0; cols_i = '0; rows_i = '0; row_stride_i = '0;
        tick(); tick();
        chk("rst.valid", {31'd0, valid_o}, 32'd0);
        chk("rst.busy",  {31'd0, busy_o},  32'd0);
        chk("rst.done",  {31'd0, done_o},  32'd0);
        chk("rst.last",  {31'd0, last_o},  32'd0);
        chk("rst.addr",  {16'd0, addr_o},  32'd0);
        rst_i = 1'b0;
        ready_i = 1'b1;
        tick();

        // basic 3x4 window
        start_win(16'h0100, 8'd4, 8'd3, 16'd4);
        for (int i = 0; i < 12; i++) begin
            chk_beat("basic", 16'h0100 + 16'(i), 8'(i / 4), 8'(i % 4), i == 11);
            tick();
        end
        chk("basic.done",  {31'd0, done_o},  32'd1);
        chk("basic.dvld",  {31'd0, valid_o}, 32'd0);
        chk("basic.dbusy", {31'd0, busy_o},  32'd1);
        tick();
        chk("basic.done2", {31'd0, done_o},  32'd0);
        chk("basic.idle",  {31'd0, busy_o},  32'd0);

        // strided tile, started in the IDLE cycle straight after DONE
        exp_a[0] = 16'h0010; exp_a[1] = 16'h0011; exp_a[2] = 16'h002C;
        exp_a[3] = 16'h002D; exp_a[4] = 16'h0048; exp_a[5] = 16'h0049;
        start_win(16'h0010, 8'd2, 8'd3, 16'd28);
        for (int i = 0; i < 6; i++) begin
            chk_beat("stride", exp_a[i], 8'(i / 2), 8'(i % 2), i == 5);
            tick();
        end
        chk("stride.done", {31'd0, done_o}, 32'd1);
        tick();

        // back-pressure 2x2
        bp_a[0] = 16'h0200; bp_a[1] = 16'h0201; bp_a[2] = 16'h0202; bp_a[3] = 16'h0203;
        rdy_seq[0] = 1; rdy_seq[1] = 0; rdy_seq[2] = 0; rdy_seq[3] = 1;
        rdy_seq[4] = 0; rdy_seq[5] = 1; rdy_seq[6] = 1;
        start_win(16'h0200, 8'd2, 8'd2, 16'd2);
        k = 0;
        for (int j = 0; j < 7; j++) begin
            ready_i = rdy_seq[j];
            chk_beat("bp", bp_a[k], 8'(k / 2), 8'(k % 2), k == 3);
            tick();
            if (rdy_seq[j]) k++;
        end
        chk("bp.done",  {31'd0, done_o},  32'd1);
        chk("bp.valid", {31'd0, valid_o}, 32'd0);
        ready_i = 1'b1;
        tick();

        // zero-column window
        start_win(16'h0500, 8'd0, 8'd5, 16'd1);
        chk("zero.valid", {31'd0, valid_o}, 32'd0);
        chk("zero.done",  {31'd0, done_o},  32'd1);
        chk("zero.busy",  {31'd0, busy_o},  32'd1);
        tick();
        chk("zero.done2", {31'd0, done_o},  32'd0);
        chk("zero.idle",  {31'd0, busy_o},  32'd0);

        // 1x1 window
        start_win(16'h00FF, 8'd1, 8'd1, 16'd0);
        chk_beat("one", 16'h00FF, 8'd0, 8'd0, 1'b1);
        tick();
        chk("one.done",  {31'd0, done_o},  32'd1);
        chk("one.valid", {31'd0, valid_o}, 32'd0);
        chk("one.hold",  {16'd0, addr_o},  32'h00FF);
        tick();

        // wrap-around with a start pulse mid-run
        wr_a[0] = 16'hFFFE; wr_a[1] = 16'hFFFF; wr_a[2] = 16'h0000; wr_a[3] = 16'h0001;
        start_win(16'hFFFE, 8'd4, 8'd1, 16'd7);
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                start_i = 1'b1; base_addr_i = 16'h1234; cols_i = 8'd9; rows_i = 8'd9;
            end else begin
                start_i = 1'b0;
            end
            chk_beat("wrap", wr_a[i], 8'd0, 8'(i), i == 3);
            tick();
        end
        start_i = 1'b0;
        chk("wrap.done", {31'd0, done_o}, 32'd1);
        tick();
        chk("wrap.idle", {31'd0, busy_o}, 32'd0);

        // reset after the 5th transfer of a 4x4 window
        start_win(16'h0300, 8'd4, 8'd4, 16'd16);
        for (int i = 0; i < 5; i++) begin
            chk_beat("rstrun", 16'h0300 + 16'((i / 4) * 16 + (i % 4)), 8'(i / 4), 8'(i % 4), 1'b0);
            tick();
        end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("rstrun.valid", {31'd0, valid_o}, 32'd0);
        chk("rstrun.busy",  {31'd0, busy_o},  32'd0);
        chk("rstrun.done",  {31'd0, done_o},  32'd0);
        chk("rstrun.addr",  {16'd0, addr_o},  32'd0);
        chk("rstrun.row",   {24'd0, row_o},   32'd0);
        chk("rstrun.col",   {24'd0, col_o},   32'd0);
        chk("rstrun.last",  {31'd0, last_o},  32'd0);
        tick();
        chk("rstrun.nodone", {31'd0, done_o}, 32'd0);
        start_win(16'h0400, 8'd1, 8'd2, 16'h0010);
        chk_beat("restart0", 16'h0400, 8'd0, 8'd0, 1'b0);
        tick();
        chk_beat("restart1", 16'h0410, 8'd1, 8'd0, 1'b1);
        tick();
        chk("restart.done", {31'd0, done_o}, 32'd1);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
